// File: rtl/led_pattern_engine_if.sv
// rtl/led_pattern_engine_if.sv - config valid/ready port bundle for the LED pattern engine
interface led_pattern_engine_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_count;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - multi-channel LED off/solid/blink/blink-code driver on a slow tick
module led_pattern_engine #(
    parameter int NUM_CH      = 4,
    parameter int CLK_HZ      = 3_000_000,
    parameter int TICK_HZ     = 1000,
    parameter int PULSE_TICKS = 200,
    parameter int GAP_TICKS   = 1000,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_engine_if.slave  cfg,
    output logic [NUM_CH-1:0]    led,
    output logic                 tick_out
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int DIV_W  = $clog2(DIV);
    localparam int PH_MAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_SOLID,
        S_BLINK_ON,
        S_BLINK_OFF,
        S_CODE_ON,
        S_CODE_OFF,
        S_CODE_GAP
    } ch_state_t;

    logic [DIV_W-1:0] div_cnt;

    logic             pend;
    logic [CH_W-1:0]  p_ch;
    logic [1:0]       p_mode;
    logic [CNT_W-1:0] p_count;

    logic             accept;
    logic             apply;

    ch_state_t        state_q  [NUM_CH];
    ch_state_t        state_d  [NUM_CH];
    logic [PH_W-1:0]  phase_q  [NUM_CH];
    logic [PH_W-1:0]  phase_d  [NUM_CH];
    logic [CNT_W-1:0] pulses_q [NUM_CH];
    logic [CNT_W-1:0] pulses_d [NUM_CH];
    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] count_d  [NUM_CH];
    logic [NUM_CH-1:0] led_d;

    // The registered tick pulse is the pattern time base: a pending write
    // stored in cycle t can only meet a tick_out from cycle t+1 onward.
    assign cfg.cfg_ready = ~pend;
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign apply         = tick_out && pend;

    // Prescaler 0..DIV-1; tick_out registers the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= (div_cnt == DIV_W'(DIV - 1));
            div_cnt  <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;
        end
    end

    // Single-entry pending write; out-of-range channels are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            p_ch    <= '0;
            p_mode  <= '0;
            p_count <= '0;
        end else if (apply) begin
            pend <= 1'b0;
        end else if (accept && (32'(cfg.cfg_ch) < NUM_CH)) begin
            pend    <= 1'b1;
            p_ch    <= cfg.cfg_ch;
            p_mode  <= cfg.cfg_mode;
            p_count <= cfg.cfg_count;
        end
    end

    // Channel state registers and registered LED drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= S_OFF;
                phase_q[i]  <= '0;
                pulses_q[i] <= '0;
                count_q[i]  <= '0;
            end
            led <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                phase_q[i]  <= phase_d[i];
                pulses_q[i] <= pulses_d[i];
                count_q[i]  <= count_d[i];
            end
            led <= led_d;
        end
    end

    // Per-channel next state: apply a pending write, else advance on the tick.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        pulses_d = pulses_q;
        count_d  = count_q;
        led_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick_out) begin
                if (apply && (p_ch == CH_W'(i))) begin
                    phase_d[i]  = '0;
                    pulses_d[i] = p_count;
                    count_d[i]  = p_count;
                    case (p_mode)
                        2'd1:    state_d[i] = S_SOLID;
                        2'd2:    state_d[i] = S_BLINK_ON;
                        2'd3:    state_d[i] = (p_count == '0) ? S_OFF : S_CODE_ON;
                        default: state_d[i] = S_OFF;
                    endcase
                end else begin
                    case (state_q[i])
                        S_BLINK_ON, S_BLINK_OFF, S_CODE_ON, S_CODE_OFF: begin
                            if (phase_q[i] == PH_W'(PULSE_TICKS - 1)) begin
                                phase_d[i] = '0;
                                case (state_q[i])
                                    S_BLINK_ON:  state_d[i] = S_BLINK_OFF;
                                    S_BLINK_OFF: state_d[i] = S_BLINK_ON;
                                    S_CODE_OFF:  state_d[i] = S_CODE_ON;
                                    default: begin
                                        // Last lit pulse of the burst goes straight to the gap.
                                        if (pulses_q[i] == CNT_W'(1)) begin
                                            state_d[i] = S_CODE_GAP;
                                        end else begin
                                            state_d[i]  = S_CODE_OFF;
                                            pulses_d[i] = pulses_q[i] - 1'b1;
                                        end
                                    end
                                endcase
                            end else begin
                                phase_d[i] = phase_q[i] + 1'b1;
                            end
                        end
                        S_CODE_GAP: begin
                            if (phase_q[i] == PH_W'(GAP_TICKS - 1)) begin
                                phase_d[i]  = '0;
                                pulses_d[i] = count_q[i];
                                state_d[i]  = S_CODE_ON;
                            end else begin
                                phase_d[i] = phase_q[i] + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            led_d[i] = (state_d[i] == S_SOLID) || (state_d[i] == S_BLINK_ON) ||
                       (state_d[i] == S_CODE_ON);
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed and random config stimulus against a tick-count LED model
module tb_led_pattern_engine;
    localparam int NUM_CH = 5;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 4;
    localparam int DIV    = 10;
    localparam int P      = 2;
    localparam int G      = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] led;
    logic              tick_out;

    led_pattern_engine_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_bus ();

    led_pattern_engine #(
        .NUM_CH(NUM_CH), .CLK_HZ(100), .TICK_HZ(10),
        .PULSE_TICKS(P), .GAP_TICKS(G), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_bus), .led(led), .tick_out(tick_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Reference model: ticks elapsed since each channel's apply
    int                cyc;
    bit                m_tick, m_ready, m_pend;
    int                p_ch, p_mode, p_cnt;
    int                m_mode [NUM_CH];
    int                m_cnt  [NUM_CH];
    int                m_k    [NUM_CH];
    logic [NUM_CH-1:0] m_led;

    function automatic bit led_of(input int mode, input int n, input int k);
        int pos;
        case (mode)
            1: return 1'b1;
            2: return ((k / P) % 2) == 0;
            3: begin
                if (n == 0) return 1'b0;
                pos = k % ((2 * n - 1) * P + G);
                return (pos < (2 * n - 1) * P) && (((pos / P) % 2) == 0);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_tick = 0; m_ready = 1; m_pend = 0; m_led = '0;
        p_ch = 0; p_mode = 0; p_cnt = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_k[i] = 0;
        end
    endtask

    task automatic step();
        bit apply, acc;
        check("led", 32'(led), 32'(m_led));
        check("tick_out", 32'(tick_out), 32'(m_tick));
        check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_ready));
        apply = m_tick && m_pend;
        acc   = cfg_bus.cfg_valid && m_ready && (int'(cfg_bus.cfg_ch) < NUM_CH);
        if (m_tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply && i == p_ch) begin
                    m_mode[i] = p_mode; m_cnt[i] = p_cnt; m_k[i] = 0;
                end else begin
                    m_k[i]++;
                end
            end
        end
        if (apply) m_pend = 0;
        else if (acc) begin
            m_pend = 1;
            p_ch   = int'(cfg_bus.cfg_ch);
            p_mode = int'(cfg_bus.cfg_mode);
            p_cnt  = int'(cfg_bus.cfg_count);
        end
        m_ready = !m_pend;
        for (int i = 0; i < NUM_CH; i++) m_led[i] = led_of(m_mode[i], m_cnt[i], m_k[i]);
        cyc++;
        m_tick = (cyc % DIV) == 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input int ch, input int mode, input int count);
        bit done = 0;
        int n    = 0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = CH_W'(ch);
        cfg_bus.cfg_mode  = 2'(mode);
        cfg_bus.cfg_count = CNT_W'(count);
        while (!done && n < 200) begin
            done = m_ready;
            step();
            n++;
        end
        cfg_bus.cfg_valid = 1'b0;
        check("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_tick", 32'(tick_out), 32'd0);
        check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_mode  = '0;
        cfg_bus.cfg_count = '0;
        model_reset();
        do_reset();

        // idle ticks, then blink on ch0 transferred in cycle 3
        idle(3);
        send(0, 2, 0);
        idle(60);

        // code burst of 3 on ch1, two full periods
        send(1, 3, 3);
        idle(320);

        // back-to-back writes, second held off; out-of-range channel dropped
        send(2, 1, 0);
        send(3, 2, 0);
        send(7, 1, 0);
        idle(5);
        send(6, 2, 0);
        idle(30);

        // reset in the middle of a lit code pulse
        send(1, 3, 2);
        idle(15);
        do_reset();
        idle(20);

        // code with zero count stays dark; solid stays lit
        send(2, 3, 0);
        send(3, 1, 0);
        idle(40);

        // random writes, including rewrites mid-pattern
        for (int r = 0; r < 25; r++) begin
            send($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 4));
            idle($urandom_range(0, 60));
        end
        idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
